// File: rtl/block_sequencer.sv
// Bit-serial control sequencer: fetches, decodes and executes a tiny
// 4-bit-opcode ISA, driving an external ALU and data memory.
module block_sequencer #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  output logic [ADDR_WIDTH-1:0] prog_addr,
  input  logic [ADDR_WIDTH+3:0] prog_data,
  input  logic                  zero_flag,
  output logic [3:0]            alu_op,
  output logic                  wr_cr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic                  halted,
  output logic [2:0]            state
);

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_LD  = 4'd1;
  localparam logic [3:0] OP_NOT = 4'd6;
  localparam logic [3:0] OP_ST  = 4'd7;
  localparam logic [3:0] OP_STN = 4'd8;
  localparam logic [3:0] OP_JMP = 4'd9;
  localparam logic [3:0] OP_JZ  = 4'd10;
  localparam logic [3:0] OP_HLT = 4'd15;

  typedef enum logic [2:0] {
    FETCH   = 3'd0,
    DECODE  = 3'd1,
    EXECUTE = 3'd2,
    WRITE   = 3'd3,
    HALT    = 3'd4
  } state_t;

  typedef struct packed {
    logic [3:0]            op;
    logic [ADDR_WIDTH-1:0] arg;
  } instr_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  instr_t                ir_q, ir_d;

  logic [3:0] raw_op;
  logic       is_alu, is_st, is_jmp, is_jz, is_hlt;
  logic       rd_raw, wr_raw, mw_raw;

  // The datapath width lives outside this block; kept for the parameter list.
  logic [DATA_WIDTH-1:0] unused_dw;
  assign unused_dw = '0;

  assign raw_op    = prog_data[ADDR_WIDTH+3:ADDR_WIDTH];
  assign prog_addr = pc_q;
  assign mem_addr  = ir_q.arg;
  assign halted    = (state_q == HALT);
  assign state     = state_q;

  always_comb begin
    is_alu = 1'b0;
    is_st  = 1'b0;
    is_jmp = 1'b0;
    is_jz  = 1'b0;
    is_hlt = 1'b0;
    unique case (1'b1)
      (ir_q.op >= OP_LD) && (ir_q.op <= OP_NOT): is_alu = 1'b1;
      (ir_q.op == OP_ST) || (ir_q.op == OP_STN): is_st  = 1'b1;
      (ir_q.op == OP_JMP):                       is_jmp = 1'b1;
      (ir_q.op == OP_JZ):                        is_jz  = 1'b1;
      (ir_q.op == OP_HLT):                       is_hlt = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    alu_op  = OP_NOP;
    rd_raw  = 1'b0;
    wr_raw  = 1'b0;
    mw_raw  = 1'b0;
    case (state_q)
      FETCH: state_d = DECODE;
      DECODE: begin
        // Reserved codes are folded to NOP so they look like NOP downstream.
        if ((raw_op >= 4'd11) && (raw_op <= 4'd14))
          ir_d.op = OP_NOP;
        else
          ir_d.op = raw_op;
        ir_d.arg = prog_data[ADDR_WIDTH-1:0];
        state_d  = EXECUTE;
      end
      EXECUTE: begin
        alu_op = ir_q.op;
        rd_raw = is_alu;
        unique case (1'b1)
          is_jmp: begin
            pc_d    = ir_q.arg;
            state_d = FETCH;
          end
          is_jz: begin
            pc_d    = zero_flag ? ir_q.arg
                                : pc_q + ADDR_WIDTH'(1);
            state_d = FETCH;
          end
          is_hlt:  state_d = HALT;
          default: state_d = WRITE;
        endcase
      end
      WRITE: begin
        alu_op  = ir_q.op;
        wr_raw  = is_alu;
        mw_raw  = is_st;
        pc_d    = pc_q + ADDR_WIDTH'(1);
        state_d = FETCH;
      end
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  // Strobes fire only on the edge that actually leaves the state.
  assign mem_rd = rd_raw & en & ~rst;
  assign wr_cr  = wr_raw & en & ~rst;
  assign mem_wr = mw_raw & en & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
    end else if (en) begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

endmodule

// File: tb/tb_block_sequencer.sv
// Bench for block_sequencer: directed scenarios plus a random program run
// compared cycle by cycle against an instruction-level reference model.
module tb_block_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        zero_flag;
  logic [11:0] prog_data;
  logic [7:0]  prog_addr;
  logic [3:0]  alu_op;
  logic        wr_cr;
  logic [7:0]  mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic        halted;
  logic [2:0]  state;

  block_sequencer #(.DATA_WIDTH(1), .ADDR_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .en(en),
    .prog_addr(prog_addr), .prog_data(prog_data),
    .zero_flag(zero_flag), .alu_op(alu_op), .wr_cr(wr_cr),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .halted(halted), .state(state)
  );

  always #5 clk = ~clk;

  logic [11:0] rom [256];

  always @(posedge clk) prog_data <= rom[prog_addr];

  int n_chk = 0;
  int n_err = 0;

  // reference model: pc, phase within current instruction, halted
  logic [7:0] m_pc;
  logic [2:0] m_k;
  logic       m_halt;

  logic [7:0] o_pa, o_ma;
  logic [3:0] o_alu;
  logic [2:0] o_st;
  logic       o_wr, o_mw, o_rd, o_halt;
  int         n_wr, n_mw, n_rd;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp,
               $time);
    end
  endtask

  task automatic step(input logic e, input logic z, input logic r);
    logic [11:0] ins;
    logic [3:0]  op;
    logic [7:0]  arg;
    logic        alu, st, run, busy;
    @(negedge clk);
    en = e;
    zero_flag = z;
    rst = r;
    #1;
    ins  = rom[m_pc];
    op   = ins[11:8];
    arg  = ins[7:0];
    alu  = (op >= 4'd1) && (op <= 4'd6);
    st   = (op == 4'd7) || (op == 4'd8);
    run  = e && !r && !m_halt;
    busy = !m_halt && (m_k >= 3'd2);
    chk("state", 32'(state), 32'(m_halt ? 3'd4 : m_k));
    chk("prog_addr", 32'(prog_addr), 32'(m_pc));
    chk("halted", 32'(halted), 32'(m_halt));
    chk("alu_op", 32'(alu_op),
        32'((busy && !(op >= 4'd11 && op <= 4'd14)) ? op : 4'd0));
    chk("mem_rd", 32'(mem_rd), 32'(run && m_k == 3'd2 && alu));
    chk("wr_cr", 32'(wr_cr), 32'(run && m_k == 3'd3 && alu));
    chk("mem_wr", 32'(mem_wr), 32'(run && m_k == 3'd3 && st));
    if (busy) chk("mem_addr", 32'(mem_addr), 32'(arg));
    o_pa = prog_addr; o_ma = mem_addr; o_alu = alu_op; o_st = state;
    o_wr = wr_cr; o_mw = mem_wr; o_rd = mem_rd; o_halt = halted;
    n_wr += int'(wr_cr);
    n_mw += int'(mem_wr);
    n_rd += int'(mem_rd);
    @(posedge clk);
    if (r) begin
      m_pc = 8'd0; m_k = 3'd0; m_halt = 1'b0;
    end else if (e && !m_halt) begin
      case (m_k)
        3'd0, 3'd1: m_k = m_k + 3'd1;
        3'd2: begin
          if (op == 4'd9) begin
            m_pc = arg; m_k = 3'd0;
          end else if (op == 4'd10) begin
            m_pc = z ? arg : m_pc + 8'd1; m_k = 3'd0;
          end else if (op == 4'd15) begin
            m_halt = 1'b1;
          end else begin
            m_k = 3'd3;
          end
        end
        default: begin
          m_pc = m_pc + 8'd1; m_k = 3'd0;
        end
      endcase
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 12'h000;
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b1);
    n_wr = 0; n_mw = 0; n_rd = 0;
  endtask

  initial begin
    logic [3:0] op;
    logic       e, z, r;
    int         hcnt;
    rst = 1'b1; en = 1'b0; zero_flag = 1'b0;
    clear_rom();
    repeat (2) @(posedge clk);
    m_pc = 8'd0; m_k = 3'd0; m_halt = 1'b0;

    // LD then ST timing
    clear_rom();
    rom[0] = 12'h105; rom[1] = 12'h706; rom[2] = 12'hF00;
    do_reset();
    for (int c = 1; c <= 9; c++) begin
      step(1'b1, 1'b0, 1'b0);
      if (c == 4) chk("s1_wr_cr_c4", 32'(o_wr), 32'd1);
      if (c == 8) chk("s1_mem_wr_c8", 32'(o_mw), 32'd1);
      if (c == 8) chk("s1_mem_addr_c8", 32'(o_ma), 32'h06);
      if (c == 9) chk("s1_pc_c9", 32'(o_pa), 32'd2);
    end

    // JMP
    clear_rom();
    rom[0] = 12'h920; rom[8'h20] = 12'hF00;
    do_reset();
    for (int c = 1; c <= 8; c++) begin
      step(1'b1, 1'b0, 1'b0);
      if (c == 4) chk("s2_jmp_pa", 32'(o_pa), 32'h20);
    end
    chk("s2_no_strobes", 32'(n_wr + n_mw + n_rd), 32'd0);

    // JZ taken / not taken
    for (int t = 0; t < 2; t++) begin
      clear_rom();
      rom[0] = 12'h903; rom[3] = 12'hA10;
      do_reset();
      for (int c = 1; c <= 7; c++) begin
        step(1'b1, t == 0, 1'b0);
        if (c == 7) chk("s3_jz_pa", 32'(o_pa), (t == 0) ? 32'h10 : 32'h04);
      end
    end

    // pc wrap with NOP and reserved opcode 12
    for (int t = 0; t < 2; t++) begin
      clear_rom();
      rom[0] = 12'h9FF;
      rom[8'hFF] = (t == 0) ? 12'h033 : 12'hC33;
      do_reset();
      for (int c = 1; c <= 8; c++) begin
        step(1'b1, 1'b0, 1'b0);
        if (c == 6) chk("s4_exec_alu_op", 32'(o_alu), 32'd0);
        if (c == 8) chk("s4_wrap_pa", 32'(o_pa), 32'd0);
      end
      chk("s4_no_strobes", 32'(n_wr + n_mw + n_rd), 32'd0);
    end

    // stall during WRITE of AND
    clear_rom();
    rom[0] = 12'h344; rom[1] = 12'hF00;
    do_reset();
    repeat (3) step(1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      step(1'b0, 1'b0, 1'b0);
      chk("s5_stall_wr", 32'(o_wr), 32'd0);
      chk("s5_stall_state", 32'(o_st), 32'd3);
    end
    step(1'b1, 1'b0, 1'b0);
    chk("s5_release_wr", 32'(o_wr), 32'd1);
    chk("s5_wr_count", 32'(n_wr), 32'd1);

    // HLT holds, then reset clears it
    clear_rom();
    rom[0] = 12'hF00;
    do_reset();
    repeat (3) step(1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 10; c++) begin
      step(1'($urandom_range(0, 1)), 1'b0, 1'b0);
      chk("s6_halted", 32'(o_halt), 32'd1);
      chk("s6_state", 32'(o_st), 32'd4);
    end
    step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    chk("rst_state", 32'(o_st), 32'd0);
    chk("rst_halted", 32'(o_halt), 32'd0);
    chk("rst_pc", 32'(o_pa), 32'd0);
    chk("rst_alu_op", 32'(o_alu), 32'd0);

    // reset during WRITE of ST suppresses mem_wr
    clear_rom();
    rom[0] = 12'h905; rom[5] = 12'h706;
    do_reset();
    repeat (6) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    chk("s7_rst_no_mem_wr", 32'(o_mw), 32'd0);
    chk("s7_rst_in_write", 32'(o_st), 32'd3);
    step(1'b1, 1'b0, 1'b0);
    chk("s7_pc_after_rst", 32'(o_pa), 32'd0);
    chk("s7_state_after_rst", 32'(o_st), 32'd0);

    // random program, random en / zero_flag / rare reset
    for (int i = 0; i < 256; i++) begin
      op = ($urandom_range(0, 99) < 2) ? 4'd15
                                       : 4'($urandom_range(0, 14));
      rom[i] = {op, 8'($urandom_range(0, 255))};
    end
    do_reset();
    hcnt = 0;
    for (int c = 0; c < 3000; c++) begin
      r = ($urandom_range(0, 199) == 0) || (hcnt > 12);
      e = ($urandom_range(0, 3) != 0);
      z = 1'($urandom_range(0, 1));
      step(e, z, r);
      hcnt = m_halt ? hcnt + 1 : 0;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
